// File: rtl/data_packer_unit_pkg.sv
// Shared definitions for the reduce -> packer -> trace-buffer stages:
// firmware opcodes, default vector geometry and the lane vector type.
package data_packer_unit_pkg;

  localparam int PKG_N          = 8;
  localparam int PKG_DATA_WIDTH = 32;

  localparam logic [7:0] FW_PASS = 8'd0;
  localparam logic [7:0] FW_PACK = 8'd1;

  // Lane 0 is the least significant element of the packed vector.
  typedef logic [PKG_N-1:0][PKG_DATA_WIDTH-1:0] vec_t;

  // Any opcode other than FW_PACK falls back to pass-through.
  function automatic logic is_pack(input logic [7:0] op);
    return op == FW_PACK;
  endfunction

endpackage

// File: rtl/data_packer_unit_pack_lane.sv
// One chain's pack buffer: appends scalars slot by slot and presents a
// zero-padded vector whenever the chain fills up or is flushed by eof.
module pack_lane #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            sel,
  input  logic                            valid,
  input  logic                            flush,
  input  logic [DATA_WIDTH-1:0]           elem,
  output logic                            emit,
  output logic [N-1:0][DATA_WIDTH-1:0]    vec
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [N-1:0][DATA_WIDTH-1:0] buf_q;
  logic [CNT_W-1:0]             cnt_q;

  // Slots above cnt_q are always zero, so the buffer itself is the padding.
  always_comb begin
    vec = buf_q;
    if (valid) vec[cnt_q] = elem;
    emit = sel && (valid ? ((cnt_q == LAST) || flush)
                         : (flush && (cnt_q != '0)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (sel) begin
      if (emit) begin
        buf_q <= '0;
        cnt_q <= '0;
      end else if (valid) begin
        buf_q[cnt_q] <= elem;
        cnt_q        <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_packer_unit.sv
// Per-chain scalar packer between the reduce stage and the trace buffer;
// pass-through chains forward vectors, firmware loads while tracing is low.
module data_packer_unit
  import data_packer_unit_pkg::*;
#(
  parameter int N          = PKG_N,
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int MAX_CHAINS = 4,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [0:MAX_CHAINS-1][7:0] INITIAL_FIRMWARE = {MAX_CHAINS{FW_PASS}},
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic [1:0]                    eof_in,
  input  logic [1:0]                    bof_in,
  input  logic [CW-1:0]                 chainId_in,
  input  logic                          tracing,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]  vector_in,
  output logic                          valid_out,
  output logic [N-1:0][DATA_WIDTH-1:0]  vector_out,
  output logic [1:0]                    eof_out,
  output logic [1:0]                    bof_out,
  output logic [CW-1:0]                 chainId_out
);

  logic [7:0]                   fw_q [MAX_CHAINS];
  logic [7:0]                   byte_counter;
  logic [MAX_CHAINS-1:0]        lane_emit;
  logic [N-1:0][DATA_WIDTH-1:0] lane_vec [MAX_CHAINS];

  for (genvar i = 0; i < MAX_CHAINS; i++) begin : g_lane
    pack_lane #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (!tracing),
      .sel   (tracing && (chainId_in == CW'(i)) && is_pack(fw_q[i])),
      .valid (valid_in),
      .flush (|eof_in),
      .elem  (vector_in[0]),
      .emit  (lane_emit[i]),
      .vec   (lane_vec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out    <= 1'b0;
      vector_out   <= '0;
      eof_out      <= '0;
      bof_out      <= '0;
      chainId_out  <= '0;
      byte_counter <= '0;
      for (int i = 0; i < MAX_CHAINS; i++) fw_q[i] <= INITIAL_FIRMWARE[i];
    end else begin
      eof_out     <= eof_in;
      bof_out     <= bof_in;
      chainId_out <= chainId_in;
      if (!tracing) begin
        valid_out <= 1'b0;
        // Firmware bytes arrive in chain order; extra bytes are counted but dropped.
        if (configId == PERSONAL_CONFIG_ID) begin
          if (byte_counter < 8'(MAX_CHAINS)) fw_q[byte_counter[CW-1:0]] <= configData;
          if (byte_counter != 8'hFF) byte_counter <= byte_counter + 8'd1;
        end else begin
          byte_counter <= '0;
        end
      end else if (is_pack(fw_q[chainId_in])) begin
        valid_out <= lane_emit[chainId_in];
        if (lane_emit[chainId_in]) vector_out <= lane_vec[chainId_in];
      end else begin
        valid_out  <= valid_in;
        vector_out <= vector_in;
      end
    end
  end

endmodule

// File: tb/tb_data_packer_unit.sv
// Directed bench for data_packer_unit: reset, config, pass-through, packing,
// flushes, chain interleave and reconfiguration discard.
module tb_data_packer_unit;
  import data_packer_unit_pkg::*;

  typedef logic [7:0][31:0] vec8_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [1:0]  eof_in = '0;
  logic [1:0]  bof_in = '0;
  logic [1:0]  chainId_in = '0;
  logic        tracing = 1'b1;
  logic [7:0]  configId = 8'h7;
  logic [7:0]  configData = '0;
  vec8_t       vector_in = '0;
  logic        valid_out;
  vec8_t       vector_out;
  logic [1:0]  eof_out;
  logic [1:0]  bof_out;
  logic [1:0]  chainId_out;

  int n_cmp = 0;
  int n_bad = 0;

  data_packer_unit dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .eof_in(eof_in), .bof_in(bof_in),
    .chainId_in(chainId_in), .tracing(tracing), .configId(configId), .configData(configData),
    .vector_in(vector_in), .valid_out(valid_out), .vector_out(vector_out),
    .eof_out(eof_out), .bof_out(bof_out), .chainId_out(chainId_out)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] eof, input logic [1:0] bof,
                       input logic [1:0] ch, input vec8_t vec);
    valid_in = v; eof_in = eof; bof_in = bof; chainId_in = ch; vector_in = vec;
    @(posedge clk); #1;
  endtask

  // Only lane 0 is meaningful to a packing chain; other lanes carry junk.
  function automatic vec8_t lane0(input logic [31:0] e);
    vec8_t r;
    for (int i = 0; i < 8; i++) r[i] = 32'hA5A5_0000 | i;
    r[0] = e;
    return r;
  endfunction

  task automatic test_reset();
    vec8_t v;
    rst_n = 1'b0;
    drive(1'b1, 2'b11, 2'b11, 2'd3, lane0(32'h1234));
    drive(1'b1, 2'b11, 2'b11, 2'd3, lane0(32'h1234));
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_out); end
    n_cmp++; if (vector_out !== '0) begin n_bad++; $display("FAIL rst_vector: got %h want 0", vector_out); end
    n_cmp++; if (eof_out !== 2'b00) begin n_bad++; $display("FAIL rst_eof: got %b want 00", eof_out); end
    n_cmp++; if (bof_out !== 2'b00) begin n_bad++; $display("FAIL rst_bof: got %b want 00", bof_out); end
    n_cmp++; if (chainId_out !== 2'd0) begin n_bad++; $display("FAIL rst_chain: got %0d want 0", chainId_out); end
    rst_n = 1'b1;
    // Initial firmware is all pass-through.
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 8; i++) v[i] = 32'(c * 16 + i + 1);
      drive(1'b1, 2'b00, 2'b00, 2'(c), v);
      n_cmp++; if (valid_out !== 1'b1 || vector_out !== v || chainId_out !== 2'(c)) begin
        n_bad++; $display("FAIL init_fw_pass ch%0d: got valid=%b chain=%0d vec=%h want valid=1 vec=%h", c, valid_out, chainId_out, vector_out, v);
      end
    end
  endtask

  task automatic test_config();
    vec8_t v;
    tracing = 1'b0; configId = 8'h00;
    configData = FW_PACK;
    drive(1'b1, 2'b10, 2'b01, 2'd1, lane0(32'd99));
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL cfg_valid: got %b want 0", valid_out); end
    n_cmp++; if (eof_out !== 2'b10 || bof_out !== 2'b01 || chainId_out !== 2'd1) begin
      n_bad++; $display("FAIL cfg_follow: got eof=%b bof=%b chain=%0d want 10 01 1", eof_out, bof_out, chainId_out);
    end
    configId = 8'h07;
    drive(1'b0, 2'b00, 2'b00, 2'd0, '0);
    configId = 8'h00;
    configData = FW_PASS; drive(1'b0, 2'b00, 2'b00, 2'd0, '0);
    configData = FW_PACK; drive(1'b0, 2'b00, 2'b00, 2'd0, '0);
    configData = FW_PACK; drive(1'b0, 2'b00, 2'b00, 2'd0, '0);
    configData = FW_PASS; drive(1'b0, 2'b00, 2'b00, 2'd0, '0);
    configData = FW_PACK; drive(1'b0, 2'b00, 2'b00, 2'd0, '0);
    tracing = 1'b1; configId = 8'h07;
    for (int i = 0; i < 8; i++) v[i] = 32'h300 + i;
    drive(1'b1, 2'b00, 2'b00, 2'd3, v);
    n_cmp++; if (valid_out !== 1'b1 || vector_out !== v) begin
      n_bad++; $display("FAIL cfg_ch3_pass: got valid=%b vec=%h want valid=1 vec=%h", valid_out, vector_out, v);
    end
  endtask

  task automatic test_pass();
    vec8_t v;
    for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
    drive(1'b1, 2'b00, 2'b10, 2'd0, v);
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL pass_valid: got %b want 1", valid_out); end
    n_cmp++; if (vector_out !== v) begin n_bad++; $display("FAIL pass_vector: got %h want %h", vector_out, v); end
    n_cmp++; if (chainId_out !== 2'd0 || bof_out !== 2'b10) begin
      n_bad++; $display("FAIL pass_side: got chain=%0d bof=%b want 0 10", chainId_out, bof_out);
    end
  endtask

  task automatic test_full_pack();
    vec8_t ex;
    for (int i = 0; i < 8; i++) ex[i] = 32'((i + 1) * 10);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'b00, 2'b00, 2'd1, lane0(32'((k + 1) * 10)));
      if (k < 7) begin
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL full_early k=%0d: got %b want 0", k, valid_out); end
      end else begin
        n_cmp++; if (valid_out !== 1'b1 || vector_out !== ex || chainId_out !== 2'd1) begin
          n_bad++; $display("FAIL full_emit: got valid=%b chain=%0d vec=%h want valid=1 vec=%h", valid_out, chainId_out, vector_out, ex);
        end
      end
    end
  endtask

  task automatic test_partial_flush();
    vec8_t ex;
    ex = '0; ex[0] = 32'd5; ex[1] = 32'd6; ex[2] = 32'd7;
    drive(1'b1, 2'b00, 2'b00, 2'd1, lane0(32'd5));
    drive(1'b1, 2'b00, 2'b00, 2'd1, lane0(32'd6));
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL partial_early: got %b want 0", valid_out); end
    drive(1'b1, 2'b01, 2'b00, 2'd1, lane0(32'd7));
    n_cmp++; if (valid_out !== 1'b1 || vector_out !== ex || eof_out !== 2'b01) begin
      n_bad++; $display("FAIL partial_emit: got valid=%b eof=%b vec=%h want valid=1 eof=01 vec=%h", valid_out, eof_out, vector_out, ex);
    end
  endtask

  task automatic test_lone_eof();
    vec8_t ex;
    ex = '0; ex[0] = 32'd9; ex[1] = 32'd4;
    drive(1'b1, 2'b00, 2'b00, 2'd1, lane0(32'd9));
    drive(1'b1, 2'b00, 2'b00, 2'd1, lane0(32'd4));
    drive(1'b0, 2'b01, 2'b00, 2'd1, '0);
    n_cmp++; if (valid_out !== 1'b1 || vector_out !== ex) begin
      n_bad++; $display("FAIL lone_flush: got valid=%b vec=%h want valid=1 vec=%h", valid_out, vector_out, ex);
    end
    drive(1'b0, 2'b01, 2'b00, 2'd1, '0);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL lone_repeat: got %b want 0", valid_out); end
  endtask

  task automatic test_interleave();
    vec8_t ex1, ex2, vp;
    ex1 = '0; ex1[0] = 32'd1; ex1[1] = 32'd2; ex1[2] = 32'd3;
    ex2 = '0; ex2[0] = 32'd100; ex2[1] = 32'd200;
    for (int i = 0; i < 8; i++) vp[i] = 32'hC0 + i;
    drive(1'b1, 2'b00, 2'b00, 2'd1, lane0(32'd1));
    drive(1'b1, 2'b00, 2'b00, 2'd2, lane0(32'd100));
    drive(1'b1, 2'b00, 2'b00, 2'd1, lane0(32'd2));
    // A pass-through eof must not disturb the packing chains.
    drive(1'b1, 2'b01, 2'b00, 2'd0, vp);
    n_cmp++; if (valid_out !== 1'b1 || vector_out !== vp) begin
      n_bad++; $display("FAIL inter_pass: got valid=%b vec=%h want valid=1 vec=%h", valid_out, vector_out, vp);
    end
    drive(1'b1, 2'b00, 2'b00, 2'd2, lane0(32'd200));
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL inter_quiet: got %b want 0", valid_out); end
    drive(1'b1, 2'b01, 2'b00, 2'd1, lane0(32'd3));
    n_cmp++; if (valid_out !== 1'b1 || vector_out !== ex1 || chainId_out !== 2'd1) begin
      n_bad++; $display("FAIL inter_ch1: got valid=%b chain=%0d vec=%h want valid=1 vec=%h", valid_out, chainId_out, vector_out, ex1);
    end
    drive(1'b0, 2'b10, 2'b00, 2'd2, '0);
    n_cmp++; if (valid_out !== 1'b1 || vector_out !== ex2 || chainId_out !== 2'd2) begin
      n_bad++; $display("FAIL inter_ch2: got valid=%b chain=%0d vec=%h want valid=1 vec=%h", valid_out, chainId_out, vector_out, ex2);
    end
  endtask

  task automatic test_reconfig();
    vec8_t ex, v;
    drive(1'b1, 2'b00, 2'b00, 2'd2, lane0(32'd55));
    drive(1'b1, 2'b00, 2'b00, 2'd1, lane0(32'd11));
    tracing = 1'b0; configId = 8'h09;
    drive(1'b1, 2'b00, 2'b00, 2'd2, lane0(32'd56));
    configId = 8'h00;
    configData = FW_PACK; drive(1'b1, 2'b00, 2'b00, 2'd0, '0);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL recfg_valid: got %b want 0", valid_out); end
    configData = FW_PASS; drive(1'b0, 2'b00, 2'b00, 2'd0, '0);
    configData = FW_PACK; drive(1'b0, 2'b00, 2'b00, 2'd0, '0);
    configData = FW_PACK; drive(1'b0, 2'b00, 2'b00, 2'd0, '0);
    tracing = 1'b1; configId = 8'h09;
    for (int i = 0; i < 8; i++) v[i] = 32'h500 + i;
    drive(1'b1, 2'b00, 2'b00, 2'd1, v);
    n_cmp++; if (valid_out !== 1'b1 || vector_out !== v) begin
      n_bad++; $display("FAIL recfg_ch1_pass: got valid=%b vec=%h want valid=1 vec=%h", valid_out, vector_out, v);
    end
    ex = '0; ex[0] = 32'd66;
    drive(1'b1, 2'b01, 2'b00, 2'd2, lane0(32'd66));
    n_cmp++; if (valid_out !== 1'b1 || vector_out !== ex) begin
      n_bad++; $display("FAIL recfg_discard: got valid=%b vec=%h want valid=1 vec=%h", valid_out, vector_out, ex);
    end
    ex = '0; ex[0] = 32'd1;
    drive(1'b1, 2'b01, 2'b00, 2'd0, lane0(32'd1));
    n_cmp++; if (valid_out !== 1'b1 || vector_out !== ex) begin
      n_bad++; $display("FAIL recfg_ch0_pack: got valid=%b vec=%h want valid=1 vec=%h", valid_out, vector_out, ex);
    end
    drive(1'b0, 2'b01, 2'b00, 2'd3, '0);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL recfg_ch3_empty: got %b want 0", valid_out); end
    ex = '0; ex[0] = 32'd42;
    drive(1'b1, 2'b10, 2'b00, 2'd3, lane0(32'd42));
    n_cmp++; if (valid_out !== 1'b1 || vector_out !== ex) begin
      n_bad++; $display("FAIL recfg_ch3_pack: got valid=%b vec=%h want valid=1 vec=%h", valid_out, vector_out, ex);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_pass();
    test_full_pack();
    test_partial_flush();
    test_lone_eof();
    test_interleave();
    test_reconfig();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
